opcode_encoder: RTL and testbench

OPCODE_ENCODER -- requirements
Module: opcode_encoder

---
 rtl/opcode_pkg.sv | 60 ++++++
 rtl/opc_fifo.sv | 88 ++++++++
 rtl/opcode_encoder.sv | 120 ++++++++++++
 tb/tb_opcode_encoder.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/opcode_pkg.sv
// rtl/opcode_pkg.sv - shared constants, types and helpers for the opcode encoder
//
// Purpose : opcode nibble constants, op_sel index constants, bus widths,
//           FIFO occupancy state type and a one-hot check helper.
// Ports   : none (package).
package opcode_pkg;

  localparam int OP_SEL_W = 23;
  localparam int OPC_W    = 8;
  localparam int FLD_W    = 4;
  localparam int IDX_W    = 5;

  // Upper opcode nibble per decoder group.
  localparam logic [3:0] OPC_SINGLE = 4'h0;
  localparam logic [3:0] OPC_SUB1   = 4'h1;
  localparam logic [3:0] OPC_SUBC   = 4'hC;
  localparam logic [3:0] OPC_D      = 4'hD;
  localparam logic [3:0] OPC_E      = 4'hE;
  localparam logic [3:0] OPC_SUBF   = 4'hF;

  // Direct-range selects map to op = index - 3.
  localparam logic [IDX_W-1:0] DIRECT_OFFSET = 5'd3;

  // op_sel bit indices.
  localparam logic [IDX_W-1:0] SEL_0  = 5'd0;
  localparam logic [IDX_W-1:0] SEL_1  = 5'd1;
  localparam logic [IDX_W-1:0] SEL_2  = 5'd2;
  localparam logic [IDX_W-1:0] SEL_3  = 5'd3;
  localparam logic [IDX_W-1:0] SEL_4  = 5'd4;
  localparam logic [IDX_W-1:0] SEL_5  = 5'd5;
  localparam logic [IDX_W-1:0] SEL_6  = 5'd6;
  localparam logic [IDX_W-1:0] SEL_7  = 5'd7;
  localparam logic [IDX_W-1:0] SEL_8  = 5'd8;
  localparam logic [IDX_W-1:0] SEL_9  = 5'd9;
  localparam logic [IDX_W-1:0] SEL_10 = 5'd10;
  localparam logic [IDX_W-1:0] SEL_11 = 5'd11;
  localparam logic [IDX_W-1:0] SEL_12 = 5'd12;
  localparam logic [IDX_W-1:0] SEL_13 = 5'd13;
  localparam logic [IDX_W-1:0] SEL_14 = 5'd14;
  localparam logic [IDX_W-1:0] SEL_15 = 5'd15;
  localparam logic [IDX_W-1:0] SEL_16 = 5'd16;
  localparam logic [IDX_W-1:0] SEL_17 = 5'd17;
  localparam logic [IDX_W-1:0] SEL_18 = 5'd18;
  localparam logic [IDX_W-1:0] SEL_19 = 5'd19;
  localparam logic [IDX_W-1:0] SEL_20 = 5'd20;
  localparam logic [IDX_W-1:0] SEL_21 = 5'd21;
  localparam logic [IDX_W-1:0] SEL_22 = 5'd22;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_PARTIAL,
    ST_FULL
  } fifo_state_e;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  function automatic logic is_onehot(input logic [OP_SEL_W-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/opc_fifo.sv
// rtl/opc_fifo.sv - opcode byte FIFO with EMPTY/PARTIAL/FULL occupancy FSM
//
// Purpose : stores encoded bytes in acceptance order; head is shown
//           combinationally so a byte written on one edge is visible the
//           next cycle.
// Ports   : clk, reset (sync, active-high)
//           push, wdata  - write request/data (ignored when FULL)
//           pop          - read request (ignored when EMPTY)
//           rdata        - head byte
//           level        - stored byte count
//           state        - occupancy state
module opc_fifo
  import opcode_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  parameter int LVL_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [W-1:0]     wdata,
  input  logic             pop,
  output logic [W-1:0]     rdata,
  output logic [LVL_W-1:0] level,
  output fifo_state_e      state
);

  localparam int PTR_W = LVL_W - 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;
  fifo_state_e      state_nxt;

  assign do_push = push && (state != ST_FULL);
  assign do_pop  = pop  && (state != ST_EMPTY);
  assign rdata   = mem[rd_ptr];

  // Storage has no reset; validity is tracked by level alone.
  always_ff @(posedge clk) begin
    if (!reset && do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      state  <= ST_EMPTY;
    end else begin
      state <= state_nxt;
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: begin
        if (do_push) state_nxt = ST_PARTIAL;
      end
      ST_PARTIAL: begin
        if (do_push && !do_pop && (level == LVL_W'(DEPTH - 1))) begin
          state_nxt = ST_FULL;
        end else if (do_pop && !do_push && (level == LVL_W'(1))) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (do_pop) state_nxt = ST_PARTIAL;
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

endmodule

// File: rtl/opcode_encoder.sv
// rtl/opcode_encoder.sv - one-hot operation select to opcode byte encoder with output FIFO
//
// Purpose : encodes a one-hot op_sel plus 4-bit field into {op, fld} bytes,
//           queues them in opc_fifo, flags invalid selects with err.
//           Optional OPENC_ERRCNT_EN adds a saturating err_count output.
// Ports   : clk, reset (sync, active-high)
//           in_valid/in_ready, op_sel[22:0], field[3:0] - producer side
//           out_valid/out_ready, out_opcode[7:0]        - consumer side
//           err   - one-cycle pulse after an invalid select is accepted
//           level - stored byte count
//           err_count[7:0] - only with OPENC_ERRCNT_EN
module opcode_encoder
  import opcode_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LVL_W = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OP_SEL_W-1:0] op_sel,
  input  logic [FLD_W-1:0]    field,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OPC_W-1:0]    out_opcode,
  output logic                err,
  output logic [LVL_W-1:0]    level
`ifdef OPENC_ERRCNT_EN
  ,
  output logic [7:0]          err_count
`endif
);

  logic             accept;
  logic             pop;
  logic             sel_ok;
  logic             push;
  logic [IDX_W-1:0] sel_idx;
  logic [3:0]       enc_op;
  logic [FLD_W-1:0] enc_fld;
  logic [OPC_W-1:0] head;
  fifo_state_e      fifo_state;

  // in_ready looks at level only so it never combinationally follows out_ready.
  assign in_ready   = (level != LVL_W'(DEPTH));
  assign accept     = in_valid && in_ready;
  assign sel_ok     = is_onehot(op_sel);
  assign push       = accept && sel_ok;
  assign out_valid  = (fifo_state != ST_EMPTY);
  assign pop        = out_valid && out_ready;
  assign out_opcode = out_valid ? head : '0;

  // Index of the selected line; only meaningful when sel_ok.
  always_comb begin
    sel_idx = '0;
    for (int k = 0; k < OP_SEL_W; k++) begin
      if (op_sel[k]) sel_idx = IDX_W'(k);
    end
  end

  // Sub-coded groups share one op nibble and carry the line offset in fld[1:0].
  always_comb begin
    enc_op  = OPC_SINGLE;
    enc_fld = field;
    if (sel_idx == SEL_0) begin
      enc_op = OPC_SINGLE;
    end else if (sel_idx <= SEL_4) begin
      enc_op  = OPC_SUB1;
      enc_fld = {field[3:2], 2'(sel_idx - SEL_1)};
    end else if (sel_idx <= SEL_14) begin
      enc_op = 4'(sel_idx - DIRECT_OFFSET);
    end else if (sel_idx <= SEL_16) begin
      enc_op  = OPC_SUBC;
      enc_fld = {field[3:2], 2'(sel_idx - SEL_15)};
    end else if (sel_idx == SEL_17) begin
      enc_op = OPC_D;
    end else if (sel_idx == SEL_18) begin
      enc_op = OPC_E;
    end else begin
      enc_op  = OPC_SUBF;
      enc_fld = {field[3:2], 2'(sel_idx - SEL_19)};
    end
  end

  opc_fifo #(
    .DEPTH (DEPTH),
    .W     (OPC_W),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata ({enc_op, enc_fld}),
    .pop   (pop),
    .rdata (head),
    .level (level),
    .state (fifo_state)
  );

  // Invalid selects are consumed like valid ones but only raise err.
  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else begin
      err <= accept && !sel_ok;
    end
  end

`ifdef OPENC_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count <= '0;
    end else if (err && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_opcode_encoder.sv
// tb/tb_opcode_encoder.sv - directed self-checking bench for opcode_encoder
module tb_opcode_encoder;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [22:0] op_sel;
  logic [3:0]  field;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_opcode;
  logic        err;
  logic [2:0]  level;
`ifdef OPENC_ERRCNT_EN
  logic [7:0]  err_count;
`endif

  int tests = 0;
  int fails = 0;

  opcode_encoder #(.DEPTH(4), .LVL_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op_sel     (op_sel),
    .field      (field),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_opcode (out_opcode),
    .err        (err),
    .level      (level)
`ifdef OPENC_ERRCNT_EN
    ,
    .err_count  (err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one op for exactly one rising edge; caller ensures in_ready=1.
  task automatic send(input logic [22:0] sel, input logic [3:0] fld);
    in_valid = 1'b1;
    op_sel   = sel;
    field    = fld;
    @(negedge clk);
    in_valid = 1'b0;
    op_sel   = '0;
    field    = '0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; op_sel = '0; field = '0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_level", 32'(level), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_opcode", 32'(out_opcode), 32'h00);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_err", 32'(err), 32'd0);
`ifdef OPENC_ERRCNT_EN
    check("rst_err_count", 32'(err_count), 32'd0);
`endif
    reset = 1'b0;
    @(negedge clk);

    // bit 0, field A -> 0A one cycle later
    send(23'h1 << 0, 4'hA);
    check("enc0_valid", 32'(out_valid), 32'd1);
    check("enc0_opcode", 32'(out_opcode), 32'h0A);
    check("enc0_level", 32'(level), 32'd1);
    pop_one();
    check("enc0_drain_valid", 32'(out_valid), 32'd0);
    check("enc0_drain_opcode", 32'(out_opcode), 32'h00);

    // sub-coded groups, checked in order
    send(23'h1 << 3, 4'b1100);
    send(23'h1 << 16, 4'b0110);
    send(23'h1 << 22, 4'b0000);
    check("sub_level", 32'(level), 32'd3);
    check("sub_b3", 32'(out_opcode), 32'h1E);
    pop_one();
    check("sub_b16", 32'(out_opcode), 32'hC5);
    pop_one();
    check("sub_b22", 32'(out_opcode), 32'hF3);
    pop_one();
    check("sub_empty", 32'(out_valid), 32'd0);

    // back-pressure: fill to DEPTH, fifth op held
    send(23'h1 << 5, 4'h0);
    send(23'h1 << 6, 4'h0);
    send(23'h1 << 7, 4'h0);
    send(23'h1 << 8, 4'h0);
    check("bp_level_full", 32'(level), 32'd4);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_head", 32'(out_opcode), 32'h20);
    in_valid = 1'b1; op_sel = 23'h1 << 9; field = 4'h0;
    @(negedge clk);
    check("bp_held_level", 32'(level), 32'd4);
    check("bp_stable_head", 32'(out_opcode), 32'h20);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_out1", 32'(out_opcode), 32'h30);
    check("bp_level3", 32'(level), 32'd3);
    check("bp_in_ready_back", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0; op_sel = '0;
    check("bp_out2", 32'(out_opcode), 32'h40);
    check("bp_level_pp", 32'(level), 32'd3);
    @(negedge clk);
    check("bp_out3", 32'(out_opcode), 32'h50);
    @(negedge clk);
    check("bp_out4", 32'(out_opcode), 32'h60);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_drained", 32'(out_valid), 32'd0);
    check("bp_drained_level", 32'(level), 32'd0);

    // invalid selects: two bits set, then none
    send(23'h000003, 4'h7);
    check("inv1_err", 32'(err), 32'd1);
    check("inv1_level", 32'(level), 32'd0);
    @(negedge clk);
    check("inv1_err_drop", 32'(err), 32'd0);
    send(23'h000000, 4'h7);
    check("inv2_err", 32'(err), 32'd1);
    @(negedge clk);
    check("inv2_err_drop", 32'(err), 32'd0);
    check("inv_level", 32'(level), 32'd0);
    check("inv_out_valid", 32'(out_valid), 32'd0);
`ifdef OPENC_ERRCNT_EN
    check("inv_err_count", 32'(err_count), 32'd2);
`endif

    // concurrent push and pop at level 2
    send(23'h1 << 5, 4'h0);
    send(23'h1 << 6, 4'h0);
    check("cc_level2", 32'(level), 32'd2);
    in_valid = 1'b1; op_sel = 23'h1 << 7; field = 4'h0; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; op_sel = '0; out_ready = 1'b0;
    check("cc_level_same", 32'(level), 32'd2);
    check("cc_head", 32'(out_opcode), 32'h30);
    pop_one();
    check("cc_next", 32'(out_opcode), 32'h40);
    pop_one();
    check("cc_empty", 32'(level), 32'd0);

    // reset with level 3, coinciding accept dropped
    send(23'h1 << 8, 4'h0);
    send(23'h1 << 9, 4'h0);
    send(23'h1 << 10, 4'h0);
    check("rs_level3", 32'(level), 32'd3);
    reset = 1'b1; in_valid = 1'b1; op_sel = 23'h1; field = 4'h5;
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; op_sel = '0; field = '0;
    check("rs_level0", 32'(level), 32'd0);
    check("rs_out_valid", 32'(out_valid), 32'd0);
    check("rs_opcode", 32'(out_opcode), 32'h00);
    check("rs_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    check("rs_dropped", 32'(level), 32'd0);

    // remaining single-code groups after reset
    send(23'h1 << 17, 4'h5);
    send(23'h1 << 18, 4'h9);
    send(23'h1 << 12, 4'h1);
    check("post_b17", 32'(out_opcode), 32'hD5);
    pop_one();
    check("post_b18", 32'(out_opcode), 32'hE9);
    pop_one();
    check("post_b12", 32'(out_opcode), 32'h91);
    pop_one();
    check("post_empty", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
